// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 multi-cycle sequencer: opcodes, FSM states
// and the datapath mux-select codes driven by the control unit.
package lc3_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_OFF9  = 2'd1;
  localparam logic [1:0] PC_BASE  = 2'd2;
  localparam logic [1:0] PC_OFF11 = 2'd3;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_PC  = 2'd2;
  localparam logic [1:0] SRC_EA  = 2'd3;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_MAR = 1'b1;

  localparam logic [2:0] LINK_REG = 3'd7;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/lc3_branch_eval.sv
// Branch resolution: the instruction's nzp mask against the live condition
// codes. A zero mask can never match, so BR with nzp=000 is a no-op.
module lc3_branch_eval (
  input  logic [2:0] nzp_mask,
  input  logic       n_flag,
  input  logic       z_flag,
  input  logic       p_flag,
  output logic       taken
);

  assign taken = |(nzp_mask & {n_flag, z_flag, p_flag});

endmodule

// File: rtl/lc3_control_unit.sv
// Multi-cycle LC-3 sequencer: fetch/decode/execute/memory FSM producing all
// datapath strobes and selects, with a memory-wait watchdog and retire counter.
module lc3_control_unit
  import lc3_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int ICOUNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         ir,
  input  logic                n_flag,
  input  logic                z_flag,
  input  logic                p_flag,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ld_ir,
  output logic                ld_pc,
  output logic [1:0]          pc_sel,
  output logic                ld_mar,
  output logic                ld_reg,
  output logic [1:0]          reg_src,
  output logic [2:0]          dr,
  output logic                cc_write,
  output logic                halted,
  output logic                illegal,
  output logic                timeout_err,
  output logic [ICOUNT_W-1:0] icount
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [ICOUNT_W-1:0] icount_reg, icount_next;
  logic                illegal_reg, illegal_next;
  logic                timeout_reg, timeout_next;

  logic [3:0] opcode;
  logic       br_taken;
  logic       mem_waiting;
  logic       wait_expired;

  assign opcode = ir[15:12];

  lc3_branch_eval u_branch_eval (
    .nzp_mask (ir[11:9]),
    .n_flag   (n_flag),
    .z_flag   (z_flag),
    .p_flag   (p_flag),
    .taken    (br_taken)
  );

  // Derived from state directly (not from mem_req) to keep the decode acyclic.
  assign mem_waiting  = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready;
  assign wait_expired = (MEM_TIMEOUT != 0) && mem_waiting &&
                        ((32'(wait_cnt_reg) + 32'd1) == 32'(MEM_TIMEOUT));

  always_comb begin
    state_next   = state_reg;
    icount_next  = icount_reg;
    illegal_next = illegal_reg;
    timeout_next = timeout_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = ADDR_PC;
    ld_ir        = 1'b0;
    ld_pc        = 1'b0;
    pc_sel       = PC_INC;
    ld_mar       = 1'b0;
    ld_reg       = 1'b0;
    reg_src      = SRC_ALU;
    dr           = 3'd0;
    cc_write     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_PC;
        if (mem_ready) begin
          ld_ir      = 1'b1;
          ld_pc      = 1'b1;
          pc_sel     = PC_INC;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next   = S_ERROR;
          timeout_next = 1'b1;
        end
      end

      S_DECODE: state_next = S_EXEC;

      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
            ld_reg     = 1'b1;
            reg_src    = (opcode == OP_LEA) ? SRC_EA : SRC_ALU;
            dr         = ir[11:9];
            cc_write   = 1'b1;
            state_next = S_FETCH;
          end
          OP_BR: begin
            if (br_taken) begin
              ld_pc  = 1'b1;
              pc_sel = PC_OFF9;
            end
            state_next = S_FETCH;
          end
          OP_JMP: begin
            ld_pc      = 1'b1;
            pc_sel     = PC_BASE;
            state_next = S_FETCH;
          end
          // R7 captures the incremented PC while the PC itself is redirected.
          OP_JSR: begin
            ld_reg     = 1'b1;
            reg_src    = SRC_PC;
            dr         = LINK_REG;
            ld_pc      = 1'b1;
            pc_sel     = ir[11] ? PC_OFF11 : PC_BASE;
            state_next = S_FETCH;
          end
          OP_LD, OP_LDR, OP_ST, OP_STR: begin
            ld_mar     = 1'b1;
            state_next = S_MEM;
          end
          OP_TRAP: state_next = S_HALT;
          default: begin
            state_next   = S_ERROR;
            illegal_next = 1'b1;
          end
        endcase
        if ((state_next == S_FETCH) || (state_next == S_HALT))
          icount_next = icount_reg + ICOUNT_W'(1);
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_MAR;
        mem_we   = is_store(opcode);
        if (mem_ready) begin
          if (is_load(opcode)) begin
            ld_reg   = 1'b1;
            reg_src  = SRC_MEM;
            dr       = ir[11:9];
            cc_write = 1'b1;
          end
          state_next  = S_FETCH;
          icount_next = icount_reg + ICOUNT_W'(1);
        end else if (wait_expired) begin
          state_next   = S_ERROR;
          timeout_next = 1'b1;
        end
      end

      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_next = '0;
    if ((state_next == state_reg) && mem_waiting)
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      icount_reg   <= '0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      icount_reg   <= icount_next;
      illegal_reg  <= illegal_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign halted      = (state_reg == S_HALT);
  assign illegal     = illegal_reg;
  assign timeout_err = timeout_reg;
  assign icount      = icount_reg;

endmodule

// File: tb/tb_lc3_control_unit.sv
// Self-checking bench for lc3_control_unit: table-driven instruction vectors
// through a scoreboard queue, plus hand-written HALT/illegal/timeout/reset runs.
module tb_lc3_control_unit;

  logic        clk = 1'b0;
  logic        reset, start, n_flag, z_flag, p_flag, mem_ready;
  logic [15:0] ir;
  logic        mem_req, mem_we, addr_sel, ld_ir, ld_pc, ld_mar, ld_reg, cc_write;
  logic [1:0]  pc_sel, reg_src;
  logic [2:0]  dr;
  logic        halted, illegal, timeout_err;
  logic [15:0] icount;

  always #5 clk = ~clk;

  lc3_control_unit #(.MEM_TIMEOUT(8), .ICOUNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ir(ir),
    .n_flag(n_flag), .z_flag(z_flag), .p_flag(p_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ld_ir(ld_ir),
    .ld_pc(ld_pc), .pc_sel(pc_sel), .ld_mar(ld_mar), .ld_reg(ld_reg),
    .reg_src(reg_src), .dr(dr), .cc_write(cc_write), .halted(halted),
    .illegal(illegal), .timeout_err(timeout_err), .icount(icount)
  );

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    int          fw;
    int          mw;
    logic        ld_reg, cc, ld_pc;
    logic [1:0]  pc_sel, reg_src;
    logic [2:0]  dr;
    logic        ld_mar, to_mem, mem_we, mem_load;
  } vec_t;

  typedef struct {
    logic       mem_req, ld_reg, cc, ld_pc, ld_mar, mem_we;
    logic [1:0] pc_sel, reg_src;
    logic [2:0] dr;
  } exp_t;

  vec_t        vecs[15];
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_icount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string ph);
    exp_t e;
    if (sb.size() == 0) begin
      chk({ph, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({ph, "_mem_req"}, mem_req, e.mem_req);
    chk({ph, "_ld_reg"}, ld_reg, e.ld_reg);
    chk({ph, "_cc_write"}, cc_write, e.cc);
    chk({ph, "_ld_pc"}, ld_pc, e.ld_pc);
    chk({ph, "_ld_mar"}, ld_mar, e.ld_mar);
    chk({ph, "_mem_we"}, mem_we, e.mem_we);
    if (e.ld_pc) chk({ph, "_pc_sel"}, pc_sel, e.pc_sel);
    if (e.ld_reg) begin
      chk({ph, "_reg_src"}, reg_src, e.reg_src);
      chk({ph, "_dr"}, dr, e.dr);
    end
  endtask

  task automatic fetch_decode(input logic [15:0] iv, input logic [2:0] nzp, input int fw);
    mem_ready = 1'b0;
    for (int i = 0; i < fw; i++) begin
      #1;
      chk("fetch_wait_req", mem_req, 1);
      chk("fetch_wait_addr", addr_sel, 0);
      chk("fetch_wait_ld_ir", ld_ir, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", addr_sel, 0);
    chk("fetch_ld_ir", ld_ir, 1);
    chk("fetch_ld_pc", ld_pc, 1);
    chk("fetch_pc_sel", pc_sel, 0);
    chk("fetch_cc", cc_write, 0);
    tick();
    mem_ready = 1'b0;
    ir = iv;
    {n_flag, z_flag, p_flag} = nzp;
    #1;
    chk("decode_quiet", {mem_req, ld_ir, ld_pc, ld_reg, ld_mar, cc_write, mem_we}, 0);
    tick();
  endtask

  task automatic run_instr(input vec_t v);
    exp_t e;
    fetch_decode(v.ir, v.nzp, v.fw);
    e = '{1'b0, v.ld_reg, v.cc, v.ld_pc, v.ld_mar, 1'b0, v.pc_sel, v.reg_src, v.dr};
    sb.push_back(e);
    #1;
    cmp("exec");
    tick();
    if (v.to_mem) begin
      for (int i = 0; i < v.mw; i++) begin
        sb.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v.mem_we, 2'd0, 2'd0, 3'd0});
        #1;
        chk("mem_wait_addr", addr_sel, 1);
        cmp("mem_wait");
        tick();
      end
      mem_ready = 1'b1;
      sb.push_back('{1'b1, v.mem_load, v.mem_load, 1'b0, 1'b0, v.mem_we, 2'd0, 2'd1, v.dr});
      #1;
      chk("mem_addr", addr_sel, 1);
      cmp("mem_done");
      tick();
      mem_ready = 1'b0;
    end
    exp_icount++;
    chk("icount", icount, exp_icount);
    $display("txn ir=%04h icount=%0d", v.ir, icount);
  endtask

  task automatic do_reset_start();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_icount = 16'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ir       nzp     fw mw ldr cc ldpc pcs   rsrc  dr    mar mem we ld
    vecs[0]  = '{16'h1261, 3'b000, 0, 0, 1, 1, 0, 2'd0, 2'd0, 3'd1, 0, 0, 0, 0};
    vecs[1]  = '{16'h0405, 3'b010, 1, 0, 0, 0, 1, 2'd1, 2'd0, 3'd0, 0, 0, 0, 0};
    vecs[2]  = '{16'h0405, 3'b100, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0};
    vecs[3]  = '{16'h0005, 3'b111, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0};
    vecs[4]  = '{16'h0E05, 3'b001, 2, 0, 0, 0, 1, 2'd1, 2'd0, 3'd0, 0, 0, 0, 0};
    vecs[5]  = '{16'h5A42, 3'b000, 0, 0, 1, 1, 0, 2'd0, 2'd0, 3'd5, 0, 0, 0, 0};
    vecs[6]  = '{16'h96BF, 3'b000, 1, 0, 1, 1, 0, 2'd0, 2'd0, 3'd3, 0, 0, 0, 0};
    vecs[7]  = '{16'hEE10, 3'b000, 0, 0, 1, 1, 0, 2'd0, 2'd3, 3'd7, 0, 0, 0, 0};
    vecs[8]  = '{16'hC1C0, 3'b000, 0, 0, 0, 0, 1, 2'd2, 2'd0, 3'd0, 0, 0, 0, 0};
    vecs[9]  = '{16'h4810, 3'b000, 0, 0, 1, 0, 1, 2'd3, 2'd2, 3'd7, 0, 0, 0, 0};
    vecs[10] = '{16'h4080, 3'b000, 1, 0, 1, 0, 1, 2'd2, 2'd2, 3'd7, 0, 0, 0, 0};
    vecs[11] = '{16'h6442, 3'b000, 0, 3, 0, 0, 0, 2'd0, 2'd0, 3'd2, 1, 1, 0, 1};
    vecs[12] = '{16'h7442, 3'b000, 0, 2, 0, 0, 0, 2'd0, 2'd0, 3'd2, 1, 1, 1, 0};
    vecs[13] = '{16'h2A05, 3'b000, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd5, 1, 1, 0, 1};
    vecs[14] = '{16'h3A05, 3'b000, 2, 1, 0, 0, 0, 2'd0, 2'd0, 3'd5, 1, 1, 1, 0};

    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = 16'h0000;
    n_flag = 1'b0; z_flag = 1'b0; p_flag = 1'b0;
    exp_icount = 16'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_outputs", {mem_req, mem_we, addr_sel, ld_ir, ld_pc, pc_sel, ld_mar, ld_reg,
                          reg_src, dr, cc_write, halted, illegal, timeout_err}, 0);
    chk("reset_icount", icount, 0);
    mem_ready = 1'b1;
    tick();
    chk("idle_hold_req", mem_req, 0);
    mem_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;

    for (int k = 0; k < 15; k++) run_instr(vecs[k]);

    // TRAP halts, counts as retired, and ignores further start pulses.
    fetch_decode(16'hF025, 3'b000, 0);
    #1;
    chk("trap_exec_strobes", {ld_reg, ld_pc, cc_write, ld_mar, mem_req}, 0);
    tick();
    exp_icount++;
    chk("trap_icount", icount, exp_icount);
    for (int k = 0; k < 10; k++) begin
      start = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("halt_halted", halted, 1);
      chk("halt_mem_req", mem_req, 0);
      tick();
      start = 1'b0;
      mem_ready = 1'b0;
      tick();
    end
    chk("halt_icount_stable", icount, exp_icount);
    $display("txn trap halted=%0d icount=%0d", halted, icount);

    // Reserved opcode lands in ERROR with illegal set.
    do_reset_start();
    chk("post_reset_halted", halted, 0);
    chk("post_reset_icount", icount, 0);
    fetch_decode(16'hD000, 3'b000, 0);
    #1;
    chk("illegal_exec_ld_reg", ld_reg, 0);
    tick();
    chk("illegal_flag", illegal, 1);
    chk("illegal_no_timeout", timeout_err, 0);
    chk("illegal_icount", icount, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("illegal_sticky", illegal, 1);
    chk("illegal_mem_req", mem_req, 0);
    $display("txn illegal=%0d", illegal);

    // Fetch that never completes trips the watchdog after exactly 8 cycles.
    do_reset_start();
    chk("timeout_cleared_illegal", illegal, 0);
    mem_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("timeout_wait_req", mem_req, 1);
      chk("timeout_early", timeout_err, 0);
      tick();
    end
    chk("timeout_err", timeout_err, 1);
    chk("timeout_mem_req", mem_req, 0);
    chk("timeout_not_illegal", illegal, 0);
    $display("txn timeout_err=%0d", timeout_err);

    // Reset during a pending fetch aborts it and clears the counter.
    do_reset_start();
    chk("restart_timeout_cleared", timeout_err, 0);
    run_instr(vecs[0]);
    mem_ready = 1'b0;
    tick();
    #1;
    chk("midfetch_req_before", mem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midfetch_req_after", mem_req, 0);
    chk("midfetch_icount", icount, 0);
    mem_ready = 1'b1;
    tick();
    chk("midfetch_idle", mem_req, 0);
    mem_ready = 1'b0;
    $display("txn reset_mid_fetch icount=%0d", icount);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_control_unit.md
Name: lc3_control_unit

Overview:
Multi-cycle LC-3 sequencer. Drives fetch/decode/execute/memory phases and generates all datapath load enables and mux selects, including cc_write to the condition-code register. Consumes the n/z/p flags for BR resolution. Sits between the instruction register/memory interface and the register file, ALU, PC and CC logic.

Parameters:
MEM_TIMEOUT, 64, max cycles waiting on mem_ready before entering ERROR; 0 disables the timeout.
ICOUNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  pulse; leaves IDLE
ir  in  16  current instruction register contents
n_flag, z_flag, p_flag  in  1 each  condition codes
mem_ready  in  1  memory access complete this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
addr_sel  out  1  0=PC, 1=MAR
ld_ir  out  1  capture memory data into IR
ld_pc  out  1  load PC
pc_sel  out  2  0=PC+1, 1=PC+off9, 2=BaseR, 3=PC+off11
ld_mar  out  1  load MAR with effective address
ld_reg  out  1  register-file write enable
reg_src  out  2  0=ALU, 1=MEM, 2=PC, 3=EA
dr  out  3  destination register
cc_write  out  1  update n/z/p from the write-back value
halted, illegal, timeout_err  out  1 each  sticky status
icount  out  ICOUNT_W  retired instructions

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Only the state register and the counters are flopped. All control outputs are Moore/Mealy decode of state, ir and mem_ready.
- Reset: state=IDLE; icount=0; wait counter=0. Every output is 0. Reset mid-access aborts the access, and mem_req is 0 in the cycle after reset is sampled.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT, ERROR.
- IDLE: all outputs 0. Go to FETCH when start=1.
- FETCH: mem_req=1, addr_sel=0. When mem_ready=1, assert ld_ir=1 and ld_pc=1 with pc_sel=0, then go to DECODE.
- DECODE: one cycle, no strobes; go to EXEC.
- EXEC, by ir[15:12]:
  - ADD/AND/NOT: ld_reg=1, reg_src=0, dr=ir[11:9], cc_write=1; go to FETCH.
  - LEA: same as ALU ops, but reg_src=3; cc_write=1.
  - BR: taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p). If taken, ld_pc=1 with pc_sel=1. ir[11:9]=000 is never taken. Go to FETCH.
  - JMP/RET: ld_pc=1, pc_sel=2; go to FETCH.
  - JSR/JSRR: ld_reg=1, reg_src=2, dr=7, ld_pc=1, pc_sel=3 if ir[11] else 2; go to FETCH. R7 is written with the pre-jump PC in the same cycle.
  - LD/LDR/ST/STR: ld_mar=1; go to MEM.
  - TRAP: go to HALT.
  - RTI, LDI, STI, 1101: go to ERROR with illegal=1.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for ST/STR.
  - On mem_ready, loads assert ld_reg=1, reg_src=1, dr=ir[11:9], cc_write=1.
  - Then go to FETCH.
- cc_write is never asserted except in the cases above: never on BR, JMP, JSR, stores or fetch.
- icount increments by 1 on every transition into FETCH from EXEC or MEM, and on entry to HALT. It wraps at 2^ICOUNT_W.
- Timeout: a wait counter runs while mem_req=1 and mem_ready=0, and clears on mem_ready or on a state change. When the count reaches MEM_TIMEOUT, go to ERROR with timeout_err=1.
- HALT/ERROR: absorbing; halted=1 in HALT. Only reset exits. start is ignored outside IDLE.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- lc3_pkg: opcode localparams, state encoding, pc_sel/reg_src/addr_sel encodings.
- Sub-module lc3_branch_eval: combinational nzp-mask vs flag match → taken. Reused by any future pipelined variant.

Test Plan:
- Reset, start, ADD R1 (ir=16'h1261), mem_ready=1 each fetch → FETCH(1)/DECODE/EXEC; ld_reg=1, cc_write=1, dr=1 in EXEC; icount=1.
- BRz (ir=16'h0405) with z=1, then with n=1 → first: ld_pc=1, pc_sel=1; second: ld_pc=0; cc_write=0 in both.
- LDR (ir=16'h6442) with mem_ready delayed 3 cycles in MEM → mem_req, addr_sel=1 held 4 cycles; ld_reg=1, reg_src=1, cc_write=1 only in the ready cycle.
- STR (ir=16'h7442) → mem_we=1 in MEM; ld_reg=0 and cc_write=0 throughout.
- TRAP x25 (16'hF025) → halted=1, state held across 10 start pulses; ir=16'hD000 after reset → illegal=1.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=8 → timeout_err=1 after 8 cycles; reset asserted mid-FETCH → mem_req=0 the next cycle, icount=0.
